// File: rtl/ga_issue_queue.sv
// ---------------------------------------------------------------------------
// ga_issue_queue
//   Request buffer between the Ibex GA decode path and ga_coprocessor.
//   Decoded GA requests are queued together with a core tag. They are issued
//   to the coprocessor one at a time, each response is captured, and the
//   response is returned to the core with the tag of the head entry. The
//   head entry leaves the queue only when the core accepts its response.
//
//   Optional feature: define GA_ISSUE_TIMEOUT_EN to enable a 16-bit watchdog
//   that turns a missing coprocessor response into an error response after
//   TimeoutCycles cycles in S_WAIT.
//
// Parameters
//   Depth          queue entries (power of two, >= 2)
//   TagWidth       core tag width
//   TimeoutCycles  watchdog limit (GA_ISSUE_TIMEOUT_EN only)
//
// Ports
//   clk_i              clock
//   rst_ni             synchronous active-low reset
//   core_req_valid_i   core request valid
//   core_req_ready_o   queue can accept a request
//   core_req_i         request payload (.valid field ignored)
//   core_tag_i         tag stored with the request
//   core_resp_valid_o  response to core valid
//   core_resp_ready_i  core accepts response
//   core_resp_o        captured coprocessor response
//   core_resp_tag_o    tag of the responding entry
//   ga_req_o           request to ga_coprocessor (.valid is a 1-cycle pulse)
//   ga_resp_i          response from ga_coprocessor
//   flush_i            drop all un-issued entries
//   occupancy_o        entries held, including the in-flight head
//   busy_o             FSM not idle
// ---------------------------------------------------------------------------
package ga_pkg;

  typedef enum logic [3:0] {
    GA_ADD   = 4'd0,
    GA_SUB   = 4'd1,
    GA_MUL   = 4'd2,
    GA_DOT   = 4'd3,
    GA_WEDGE = 4'd4,
    GA_NORM  = 4'd5
  } ga_op_e;

  typedef struct packed {
    logic        valid;
    ga_op_e      op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
  } ga_req_t;

  typedef struct packed {
    logic        valid;
    logic        busy;
    logic [31:0] result;
    logic        error;
    logic        overflow;
    logic        underflow;
  } ga_resp_t;

endpackage

module ga_issue_queue
  import ga_pkg::*;
#(
  parameter int unsigned Depth         = 4,
  parameter int unsigned TagWidth      = 5,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       core_req_valid_i,
  output logic                       core_req_ready_o,
  input  ga_req_t                    core_req_i,
  input  logic [TagWidth-1:0]        core_tag_i,
  output logic                       core_resp_valid_o,
  input  logic                       core_resp_ready_i,
  output ga_resp_t                   core_resp_o,
  output logic [TagWidth-1:0]        core_resp_tag_o,
  output ga_req_t                    ga_req_o,
  input  ga_resp_t                   ga_resp_i,
  input  logic                       flush_i,
  output logic [$clog2(Depth):0]     occupancy_o,
  output logic                       busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW:0]   ptr_t;   // extra MSB is the wrap bit
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  if ((Depth < 2) || ((Depth & (Depth - 1)) != 0) || (TimeoutCycles < 2)) begin : g_bad_param
    $error("ga_issue_queue: Depth must be a power of two >= 2 and TimeoutCycles >= 2");
  end

  state_e   state_q, state_d;
  ptr_t     wr_ptr_q, wr_ptr_d;
  ptr_t     rd_ptr_q, rd_ptr_d;
  cnt_t     count_q, count_d;
  ga_resp_t resp_q, resp_d;

  ga_req_t             req_mem_q [Depth];
  logic [TagWidth-1:0] tag_mem_q [Depth];

  logic [PtrW-1:0] wr_idx, rd_idx;
  logic            full, push, pop, head_in_flight;

  assign wr_idx         = wr_ptr_q[PtrW-1:0];
  assign rd_idx         = rd_ptr_q[PtrW-1:0];
  assign full           = (count_q == cnt_t'(Depth));
  assign head_in_flight = (state_q != S_IDLE);

  // Ready ignores a same-cycle pop: a full queue never accepts.
  assign core_req_ready_o = !full && !flush_i;
  assign push             = core_req_valid_i && core_req_ready_o;
  assign pop              = (state_q == S_RESP) && core_resp_ready_i;

  // ---------------------------------------------------------------------
  // Pointer / count next state
  // ---------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    wr_ptr_d = wr_ptr_q + ptr_t'(push);
    // Flush keeps only the in-flight head. push is already blocked by flush.
    if (flush_i) begin
      wr_ptr_d = head_in_flight ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;
    end
    count_d = cnt_t'(wr_ptr_d - rd_ptr_d);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage is reset on purpose. The head payload and tag are
  // visible on ga_req_o / core_resp_tag_o in every state, and those outputs
  // must read as zero after reset; at this depth the cost is negligible.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        req_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
    end else if (push) begin
      req_mem_q[wr_idx]       <= core_req_i;
      req_mem_q[wr_idx].valid <= 1'b0;
      tag_mem_q[wr_idx]       <= core_tag_i;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
`ifdef GA_ISSUE_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      resp_q  <= '0;
`ifdef GA_ISSUE_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
`ifdef GA_ISSUE_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and response capture
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
`ifdef GA_ISSUE_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A flush in this cycle empties the queue, so do not start an issue.
        if ((count_q != '0) && !flush_i && !ga_resp_i.busy) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef GA_ISSUE_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (ga_resp_i.valid) begin
          resp_d           = '0;
          resp_d.valid     = 1'b1;
          resp_d.result    = ga_resp_i.result;
          resp_d.error     = ga_resp_i.error;
          resp_d.overflow  = ga_resp_i.overflow;
          resp_d.underflow = ga_resp_i.underflow;
          state_d          = S_RESP;
        end
`ifdef GA_ISSUE_TIMEOUT_EN
        else if (wdog_q == 16'(TimeoutCycles - 1)) begin
          resp_d       = '0;
          resp_d.valid = 1'b1;
          resp_d.error = 1'b1;
          state_d      = S_RESP;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        if (core_resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    ga_req_o          = req_mem_q[rd_idx];
    ga_req_o.valid    = (state_q == S_ISSUE);
    core_resp_valid_o = (state_q == S_RESP);
    busy_o            = (state_q != S_IDLE);
  end

  assign core_resp_o     = resp_q;
  assign core_resp_tag_o = tag_mem_q[rd_idx];
  assign occupancy_o     = count_q;

endmodule
